// File: rtl/uart_rx_slave.sv
// uart_rx_slave: UART receiver (8N1, fixed divisor) with an 8-entry receive FIFO
// behind a polled slave-bus register interface.
//   0x0 DATA   (R)  {24'b0, FIFO head}; a read of a non-empty FIFO pops it
//   0x4 STATUS (R)  {28'b0, perr, ferr, ovr, not_empty}; a read clears perr/ferr/ovr
//   0x8 CTRL   (W)  bit0 = 1 flushes the FIFO
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, PARITY state, STATUS bit3 perr).
// Without the macro, frames are 8N1 and STATUS bit3 reads 0.
module uart_rx_slave #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    input  logic              bus_req,
    input  logic              bus_wen,
    input  logic [2:0]        bus_mode,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_dat_i,
    output logic [31:0]       bus_dat_o,
    output logic              bus_ready,
    output logic              rx_irq
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned WORD_W = ADDR_W - 2;

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [WORD_W-1:0] W_DATA    = WORD_W'(0);
    localparam logic [WORD_W-1:0] W_STATUS  = WORD_W'(1);
    localparam logic [WORD_W-1:0] W_CTRL    = WORD_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              sync1_q, rx_s_q, prev_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;
    logic              ready_q;
    logic [31:0]       dat_q, dat_d;

    // FSM event strobes
    logic              push_req;
    logic              set_ferr;
    logic              set_perr;

    // Bus / FIFO control
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic [WORD_W-1:0] word;
    logic              not_empty;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              set_ovr;
    logic              flush;
    logic              clr_flags;
    logic [31:0]       status_word;

    logic              unused_bus;
    assign unused_bus = ^{bus_mode, bus_dat_i[31:1], bus_addr[1:0]};

    // Two-flop synchroniser plus a history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
            prev_q  <= rx_s_q;
        end
    end

    // Receive FSM state, bit timer and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Receive FSM next state: mid-bit sampling relative to the start edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        set_ferr = 1'b0;
        set_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s_q) begin
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave mid stop bit so the next start edge is never missed
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_s_q) begin
                        set_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if ((^shift_q) != par_q) begin
                        set_perr = 1'b1;
`endif
                    end else begin
                        push_req = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus decode, FIFO control and read-data selection
    always_comb begin
        accept    = bus_req && !ready_q;
        rd_acc    = accept && !bus_wen;
        wr_acc    = accept && bus_wen;
        word      = bus_addr[ADDR_W-1:2];
        not_empty = (count_q != '0);
        full      = (count_q == FIFO_FULL);

        pop       = rd_acc && (word == W_DATA) && not_empty;
        flush     = wr_acc && (word == W_CTRL) && bus_dat_i[0];
        clr_flags = rd_acc && (word == W_STATUS);

        // A pop in the same cycle frees the slot a full FIFO needs
        push_ok   = push_req && (!full || pop) && !flush;
        set_ovr   = push_req && full && !pop && !flush;

        status_word = {28'b0, 1'b0, ferr_q, ovr_q, not_empty};
`ifdef UART_RX_PARITY_EN
        status_word[3] = perr_q;
`endif

        dat_d = '0;
        if (rd_acc) begin
            if (word == W_DATA) begin
                if (not_empty) begin
                    dat_d = {24'b0, mem_q[rptr_q]};
                end
            end else if (word == W_STATUS) begin
                dat_d = status_word;
            end
        end

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end

        // Sticky flags: a new event in the clearing cycle wins
        ovr_d  = (ovr_q  && !clr_flags) || set_ovr;
        ferr_d = (ferr_q && !clr_flags) || set_ferr;
`ifdef UART_RX_PARITY_EN
        perr_d = (perr_q && !clr_flags) || set_perr;
`endif
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    // FIFO pointers, sticky flags and bus response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            ready_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
            ready_q <= accept;
            dat_q   <= dat_d;
        end
    end

    assign bus_ready = ready_q;
    assign bus_dat_o = dat_q;
    assign rx_irq    = (count_q != '0);

endmodule

// File: tb/tb_uart_rx_slave.sv
// Bench for uart_rx_slave: serial frames are driven onto uart_rx while a queue-based
// model tracks FIFO contents and sticky flags; a per-cycle process compares the bus
// response and rx_irq, and literal expectations pin the model.
module tb_uart_rx_slave;

    localparam int unsigned CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_wen = 1'b0;
    logic [2:0]  bus_mode = 3'd2;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_dat_i = '0;
    logic [31:0] bus_dat_o;
    logic        bus_ready;
    logic        rx_irq;

    uart_rx_slave #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (8),
        .ADDR_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .bus_req  (bus_req),
        .bus_wen  (bus_wen),
        .bus_mode (bus_mode),
        .bus_addr (bus_addr),
        .bus_dat_i(bus_dat_i),
        .bus_dat_o(bus_dat_o),
        .bus_ready(bus_ready),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0]  mq[$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;
    logic        settled = 1'b1;
    logic        exp_ready = 1'b0;
    logic        exp_chk = 1'b0;
    logic [31:0] exp_dat = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (bus_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL bus_ready: got %b expected %b at %0t", bus_ready, exp_ready, $time);
            end
            if (exp_ready && exp_chk) begin
                n_checks++;
                if (bus_dat_o !== exp_dat) begin
                    n_fail++;
                    $display("FAIL bus_dat_o: got 0x%08h expected 0x%08h at %0t", bus_dat_o, exp_dat, $time);
                end
            end
            if (settled) begin
                n_checks++;
                if (rx_irq !== (mq.size() != 0)) begin
                    n_fail++;
                    $display("FAIL rx_irq: got %b expected %b at %0t", rx_irq, (mq.size() != 0), $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        exp_ready = 1'b0;
    endtask

    // Register-map behaviour applied at the accept edge
    task automatic model_access(input logic wen, input logic [3:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd);
        rd = '0;
        case (addr[3:2])
            2'd0: if (!wen && mq.size() != 0) rd = {24'b0, mq.pop_front()};
            2'd1: if (!wen) begin
                rd = {29'b0, m_ferr, m_ovr, (mq.size() != 0)};
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
            2'd2: if (wen && wd[0]) mq.delete();
            default: rd = '0;
        endcase
    endtask

    task automatic bus_xfer(input logic wen, input logic [3:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd);
        logic [31:0] mv;
        tick();
        bus_req = 1'b1; bus_wen = wen; bus_addr = addr; bus_dat_i = wd;
        tick();
        model_access(wen, addr, wd, mv);
        bus_req = 1'b0; exp_ready = 1'b1; exp_chk = !wen; exp_dat = mv;
        @(negedge clk);
        rd = bus_dat_o;
        tick();
        exp_ready = 1'b0;
    endtask

    // Two reads with bus_req held high throughout: 2 cycles per access
    task automatic bus_read_b2b(input logic [3:0] addr, output logic [31:0] r1, output logic [31:0] r2);
        logic [31:0] mv;
        tick();
        bus_req = 1'b1; bus_wen = 1'b0; bus_addr = addr;
        tick();
        model_access(1'b0, addr, '0, mv);
        exp_ready = 1'b1; exp_chk = 1'b1; exp_dat = mv;
        @(negedge clk);
        r1 = bus_dat_o;
        tick();
        exp_ready = 1'b0;
        tick();
        model_access(1'b0, addr, '0, mv);
        bus_req = 1'b0; exp_ready = 1'b1; exp_dat = mv;
        @(negedge clk);
        r2 = bus_dat_o;
        tick();
        exp_ready = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        settled = 1'b0;
        tick();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_ok);
        uart_rx = 1'b1;
        repeat (4) tick();
        if (!stop_ok) m_ferr = 1'b1;
        else if (mq.size() < 8) mq.push_back(b);
        else m_ovr = 1'b1;
        settled = 1'b1;
    endtask

    logic [31:0] rd, rd2;
    logic [7:0]  frame55;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        tick();
        check("reset_ready", {31'b0, bus_ready}, 32'h0);
        check("reset_dat", bus_dat_o, 32'h0);
        check("reset_irq", {31'b0, rx_irq}, 32'h0);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("reset_status", rd, 32'h0);

        // Single byte
        send_frame(8'hA5, 1'b1);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("a5_status", rd, 32'h1);
        check("a5_irq", {31'b0, rx_irq}, 32'h1);
        bus_xfer(1'b0, 4'h0, '0, rd);
        check("a5_data", rd, 32'h000000A5);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("a5_status2", rd, 32'h0);

        // Short low glitch from idle
        tick();
        uart_rx = 1'b0;
        repeat (3) tick();
        uart_rx = 1'b1;
        repeat (2 * CPB) tick();
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("glitch_status", rd, 32'h0);
        bus_xfer(1'b0, 4'h8, '0, rd);
        check("ctrl_read", rd, 32'h0);

        // Overflow: nine bytes, no reads
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("ovr_status", rd, 32'h3);
        bus_read_b2b(4'h0, rd, rd2);
        check("ovr_data1", rd, 32'h1);
        check("ovr_data2", rd2, 32'h2);
        for (int i = 3; i <= 8; i++) begin
            bus_xfer(1'b0, 4'h0, '0, rd);
            check("ovr_data", rd, 32'(i));
        end
        bus_xfer(1'b0, 4'h0, '0, rd);
        check("empty_data", rd, 32'h0);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("drained_status", rd, 32'h0);

        // Framing error
        send_frame(8'h3C, 1'b0);
        repeat (CPB) tick();
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("ferr_status", rd, 32'h4);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("ferr_status2", rd, 32'h0);

        // Reset during data bit 4 of 0x55, then 0x81
        frame55 = 8'h55;
        settled = 1'b0;
        tick();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(frame55[i]);
        uart_rx = frame55[4];
        repeat (CPB / 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        uart_rx = 1'b1;
        repeat (2 * CPB) tick();
        settled = 1'b1;
        send_frame(8'h81, 1'b1);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("rst_status", rd, 32'h1);
        bus_xfer(1'b0, 4'h0, '0, rd);
        check("rst_data", rd, 32'h81);
        bus_xfer(1'b0, 4'h0, '0, rd);
        check("rst_data_empty", rd, 32'h0);

        // Flush
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("flush_pre_irq", {31'b0, rx_irq}, 32'h1);
        bus_xfer(1'b1, 4'h8, 32'h1, rd);
        bus_xfer(1'b0, 4'h4, '0, rd);
        check("flush_status", rd, 32'h0);
        bus_xfer(1'b0, 4'h0, '0, rd);
        check("flush_data", rd, 32'h0);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_slave.md
Name: uart_rx_slave

Overview:
- UART receive peripheral and bus slave for the unisys SoC.
- Consumes the top-level `uart_rx` pin and feeds received bytes to the CPU over the SoC slave bus.
- Format is 8N1, with a fixed divisor and an 8-entry receive FIFO.
- The CPU polls a status register and pops bytes from a data register.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); legal range ≥ 4; 16 in benches.
- FIFO_DEPTH, 8: receive FIFO entries; must be a power of two.
- ADDR_W, 4: width of the local byte offset on `bus_addr`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- uart_rx  in  1  asynchronous serial input, idle high
- bus_req  in  1  transfer request, held high until `bus_ready`
- bus_wen  in  1  1 = write, 0 = read
- bus_mode  in  3  access size; ignored, all accesses treated as word
- bus_addr  in  ADDR_W  byte offset within the slave
- bus_dat_i  in  32  write data
- bus_dat_o  out  32  read data, valid while `bus_ready` = 1
- bus_ready  out  1  one-cycle transfer-complete pulse
- rx_irq  out  1  level: FIFO not empty

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high on `rst`.
  - Reset clears: FSM to IDLE, FIFO pointers and count, sticky flags, `bus_ready` = 0, `bus_dat_o` = 0, `rx_irq` = 0, synchroniser flops = 1.
- Input synchroniser
  - `uart_rx` passes through 2 flops; the result is `rx_s`. A third flop holds the previous `rx_s`.
  - A start edge is `prev` = 1 and `rx_s` = 0.
- Receive FSM, states IDLE, START, DATA, STOP:
  - IDLE: on a start edge, clear the bit counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles, sample `rx_s`. If 0, go to DATA; if 1, treat as a glitch and return to IDLE with no flag set.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: push the byte. If the FIFO is full, drop the byte and set `ovr`.
    - If 0: discard the byte and set `ferr`.
    - Either way, return to IDLE (mid stop bit, so the receiver resyncs early).
- A line held low produces exactly one `ferr`. No further frames start until the line returns high and a new falling edge occurs.
- Register map (offset, word aligned; `bus_addr[1:0]` ignored; unmapped reads return 0, unmapped writes are ignored):
  - 0x0 DATA (R): {24'b0, FIFO head}. A read of a non-empty FIFO pops the head. A read of an empty FIFO returns 0 and does not pop.
  - 0x4 STATUS (R): {29'b0, ferr, ovr, not_empty}. The read returns the current value, then clears `ovr` and `ferr`. `not_empty` is not cleared.
  - 0x8 CTRL (W): a write with bit0 = 1 flushes the FIFO. Reads of CTRL return 0.
- Bus handshake
  - A request is accepted on the first cycle with `bus_req` = 1 and no transfer in flight. `bus_ready` pulses high on the next cycle with `bus_dat_o` valid.
  - Reads complete in exactly 1 cycle; the side effects (pop, flag clear) happen in the accept cycle.
  - `bus_req` still high in the cycle after `bus_ready` counts as a new request; this allows back-to-back accesses at 2 cycles each.
- Simultaneous events
  - Push and pop in the same cycle: both occur and the count is unchanged. A push into a full FIFO coinciding with a pop succeeds and does not set `ovr`.
  - A flag set by the FSM in the same cycle a STATUS read clears it: the set wins.
  - A FIFO flush coinciding with a push: the flush wins and the FIFO is empty.
- Reset mid-frame: the partial byte is lost and the FSM is in IDLE on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1. A PARITY state is inserted between DATA and STOP.
  - The even-parity mismatch check is made at STOP. On mismatch, the byte is discarded and STATUS bit3 `perr` (sticky, cleared by a STATUS read) is set.
- Undefined: no PARITY state, and STATUS bit3 reads 0.

Test Plan:
- CLKS_PER_BIT = 16; send 0xA5 in 8N1:
  - A STATUS read returns 0x1 and `rx_irq` = 1.
  - A DATA read then returns 0x000000A5, and a following STATUS read returns 0x0.
- Pulse `uart_rx` low for 3 cycles from idle → no push; STATUS = 0x0; the FSM is back in IDLE 8 cycles after the edge.
- Send 0x01..0x09 with no reads:
  - STATUS = 0x3 (`ovr` and `not_empty`).
  - Eight DATA reads return 0x01..0x08 in order; a ninth DATA read returns 0 with no pop.
- Send 0x3C with the stop bit forced to 0 → STATUS = 0x4, FIFO empty; a second STATUS read returns 0x0.
- Assert `rst` for 1 cycle during data bit 4 of 0x55, then send 0x81 → only 0x81 is received.
- Two bytes 0x11 and 0x22 received, then a CTRL write of 0x1 → STATUS = 0x0 and a DATA read returns 0.
